// File: rtl/instr_sequencer_if.sv
// Instruction sequencer bus: program load handshake, run control and processor-side outputs.
// master = program/control source, slave = instr_sequencer.
interface instr_sequencer_if;
  logic       clear;
  logic       load_valid;
  logic [9:0] load_data;
  logic [1:0] load_cycles;
  logic       load_ready;
  logic       start;
  logic [9:0] data;
  logic       w;
  logic       busy;
  logic       done;
  logic [3:0] issued;

  modport master (
    output clear, load_valid, load_data, load_cycles, start,
    input  load_ready, data, w, busy, done, issued
  );

  modport slave (
    input  clear, load_valid, load_data, load_cycles, start,
    output load_ready, data, w, busy, done, issued
  );
endinterface

// File: rtl/instr_sequencer.sv
// Buffers up to DEPTH {cycles,word} entries and issues each for cycles+1 clocks; PROG_LOOP_EN wraps the program.
// Start -> first word on the next edge; loads are refused (load_ready low) while running, clearing or full.
module instr_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  instr_sequencer_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DONE} state_t;

  state_t          state_q, state_d;
  logic [11:0]     mem [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d, adv_ptr;
  logic [1:0]      cnt_q, cnt_d;
  logic [9:0]      data_q, data_d;
  logic [3:0]      issued_q, issued_d;
  logic            load_acc, adv_end, idle_like;
  logic [11:0]     load_word, entry0, adv_entry;

  assign idle_like      = (state_q == IDLE) || (state_q == DONE);
  assign load_word      = {bus.load_cycles, bus.load_data};
  assign bus.load_ready = ~bus.clear && idle_like && (wr_q < DEPTH_P);
  assign load_acc       = bus.load_valid && bus.load_ready;
  // An empty buffer can still start when a load lands in the same cycle.
  assign entry0         = (wr_q == '0) ? load_word : mem[0];

  always_comb begin
    adv_ptr = rd_q + PW'(1);
    adv_end = 1'b0;
    if (adv_ptr == wr_q) begin
`ifdef PROG_LOOP_EN
      adv_ptr = '0;
`else
      adv_end = 1'b1;
`endif
    end
    adv_entry = mem[adv_ptr[AW-1:0]];
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    issued_d = issued_q;
    if (bus.clear) begin
      wr_d    = '0;
      state_d = IDLE;
    end else begin
      if (load_acc) wr_d = wr_q + PW'(1);
      case (state_q)
        IDLE, DONE: begin
          if (bus.start && ((wr_q != '0) || load_acc)) begin
            rd_d = '0;
            if (entry0[11:10] == 2'd0) begin
              state_d  = DONE;
              issued_d = 4'd0;
            end else begin
              state_d  = ISSUE;
              cnt_d    = entry0[11:10];
              data_d   = entry0[9:0];
              issued_d = 4'd1;
            end
          end
        end
        ISSUE, HOLD: begin
          // cnt counts the clocks still owed to the current word after this one.
          if (cnt_q != 2'd0) begin
            cnt_d   = cnt_q - 2'd1;
            state_d = HOLD;
          end else if (adv_end || (adv_entry[11:10] == 2'd0)) begin
            state_d = DONE;
          end else begin
            state_d  = ISSUE;
            rd_d     = adv_ptr;
            cnt_d    = adv_entry[11:10];
            data_d   = adv_entry[9:0];
            issued_d = issued_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= 2'd0;
      data_q   <= 10'd0;
      issued_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      issued_q <= issued_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && load_acc) mem[wr_q[AW-1:0]] <= load_word;
  end

  assign bus.busy   = (state_q == ISSUE) || (state_q == HOLD);
  assign bus.w      = bus.busy;
  assign bus.done   = (state_q == DONE);
  assign bus.data   = data_q;
  assign bus.issued = issued_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: every w-high cycle pops one expected word.
// Program runs, buffer-full, zero-cycle terminator, clear/reset mid-run, and loop mode when PROG_LOOP_EN is set.
module tb_instr_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [9:0] exp_q[$];

  instr_sequencer_if bus_if ();

  instr_sequencer #(.DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (bus_if.w === 1'b1) begin
      if (exp_q.size() == 0) chk("w_extra", 32'(bus_if.w), 32'd0);
      else chk("data", 32'(bus_if.data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [9:0] d, input logic [1:0] k);
    bus_if.load_valid  = 1'b1;
    bus_if.load_data   = d;
    bus_if.load_cycles = k;
    tick();
    bus_if.load_valid  = 1'b0;
  endtask

  task automatic expect_word(input logic [9:0] d, input int k);
    repeat (k + 1) exp_q.push_back(d);
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (n < 200) begin
      @(negedge clock);
      if (bus_if.done === 1'b1) break;
      n++;
    end
    chk(tag, 32'(bus_if.done), 32'd1);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_w"}, 32'(bus_if.w), 32'd0);
    tick();
  endtask

  initial begin
    bus_if.clear       = 1'b0;
    bus_if.load_valid  = 1'b0;
    bus_if.load_data   = 10'd0;
    bus_if.load_cycles = 2'd0;
    bus_if.start       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_data", 32'(bus_if.data), 32'd0);
    chk("rst_w", 32'(bus_if.w), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_issued", 32'(bus_if.issued), 32'd0);
    chk("rst_ready", 32'(bus_if.load_ready), 32'd1);
    tick();

    // Three-entry program, then a restart from DONE with the program retained.
    load(10'h01D, 2'd1);
    load(10'h027, 2'd2);
    load(10'h2A0, 2'd1);
    for (int r = 0; r < 2; r++) begin
      expect_word(10'h01D, 1);
      expect_word(10'h027, 2);
      expect_word(10'h2A0, 1);
      pulse_start();
      chk("run3_busy", 32'(bus_if.busy), 32'd1);
      wait_done("run3_done");
      chk("run3_data", 32'(bus_if.data), 32'h2A0);
      chk("run3_issued", 32'(bus_if.issued), 32'd3);
    end

    // Fill the buffer; the ninth load must be refused.
    pulse_clear();
    chk("clr_done", 32'(bus_if.done), 32'd0);
    for (int i = 0; i < 8; i++) load(10'(i * 37 + 5), 2'd1);
    chk("full_ready", 32'(bus_if.load_ready), 32'd0);
    load(10'h3FF, 2'd1);
    for (int i = 0; i < 8; i++) expect_word(10'(i * 37 + 5), 1);
    pulse_start();
    wait_done("full_done");
    chk("full_issued", 32'(bus_if.issued), 32'd8);

    // Zero-cycle entry terminates the program without being issued.
    pulse_clear();
    load(10'h1F9, 2'd3);
    load(10'h18D, 2'd0);
    load(10'h084, 2'd1);
    expect_word(10'h1F9, 3);
    pulse_start();
    wait_done("term_done");
    chk("term_issued", 32'(bus_if.issued), 32'd1);
    chk("term_data", 32'(bus_if.data), 32'h1F9);

    // Clear mid-HOLD, then start on an empty buffer is ignored.
    pulse_clear();
    load(10'h111, 2'd3);
    load(10'h222, 2'd3);
    expect_word(10'h111, 3);
    expect_word(10'h222, 3);
    pulse_start();
    tick();
    chk("hold_ready", 32'(bus_if.load_ready), 32'd0);
    chk("hold_busy", 32'(bus_if.busy), 32'd1);
    pulse_clear();
    exp_q.delete();
    chk("clrh_w", 32'(bus_if.w), 32'd0);
    chk("clrh_busy", 32'(bus_if.busy), 32'd0);
    chk("clrh_done", 32'(bus_if.done), 32'd0);
    chk("clrh_data", 32'(bus_if.data), 32'h111);
    chk("clrh_issued", 32'(bus_if.issued), 32'd1);
    pulse_start();
    chk("empty_start_busy", 32'(bus_if.busy), 32'd0);
    chk("empty_start_done", 32'(bus_if.done), 32'd0);
    load(10'h0AB, 2'd1);
    expect_word(10'h0AB, 1);
    pulse_start();
    wait_done("after_clr_done");
    chk("after_clr_issued", 32'(bus_if.issued), 32'd1);

    // Clear beats a simultaneous load; load with start on an empty buffer runs.
    bus_if.clear = 1'b1;
    load(10'h0CC, 2'd1);
    bus_if.clear = 1'b0;
    pulse_start();
    chk("clr_load_busy", 32'(bus_if.busy), 32'd0);
    expect_word(10'h155, 2);
    bus_if.start = 1'b1;
    load(10'h155, 2'd2);
    bus_if.start = 1'b0;
    wait_done("ld_start_done");
    chk("ld_start_issued", 32'(bus_if.issued), 32'd1);

    // Reset mid-HOLD.
    expect_word(10'h155, 2);
    pulse_start();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("rsth_data", 32'(bus_if.data), 32'd0);
    chk("rsth_w", 32'(bus_if.w), 32'd0);
    chk("rsth_busy", 32'(bus_if.busy), 32'd0);
    chk("rsth_issued", 32'(bus_if.issued), 32'd0);
    chk("rsth_ready", 32'(bus_if.load_ready), 32'd1);
    pulse_start();
    chk("rsth_start_busy", 32'(bus_if.busy), 32'd0);

`ifdef PROG_LOOP_EN
    load(10'h0A5, 2'd1);
    load(10'h15A, 2'd1);
    for (int j = 0; j < 40; j++) exp_q.push_back(((j / 2) % 2 == 0) ? 10'h0A5 : 10'h15A);
    pulse_start();
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      chk("loop_done", 32'(bus_if.done), 32'd0);
      chk("loop_issued", 32'(bus_if.issued), 32'(((j / 2) + 1) % 16));
    end
    pulse_clear();
    exp_q.delete();
    chk("loop_clr_w", 32'(bus_if.w), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of program entries (power of two, 2..16).
REQ-002 The block SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port clear  input  1  synchronous program erase: empties the buffer and returns to IDLE.
REQ-005 The block SHALL have port load_valid  input  1  load request for one program entry.
REQ-006 The block SHALL have port load_data  input  10  processor instruction word to store.
REQ-007 The block SHALL have port load_cycles  input  2  execution cycles of that instruction (1..3); 0 marks end of program.
REQ-008 The block SHALL have port load_ready  output  1  entry accepted this cycle when load_valid and load_ready are both high.
REQ-009 The block SHALL have port start  input  1  one-cycle request to begin issuing from entry 0.
REQ-010 The block SHALL have port data  output  10  instruction word driven to the processor data input.
REQ-011 The block SHALL have port w  output  1  processor write/run enable; high while an instruction is being issued.
REQ-012 The block SHALL have port busy  output  1  high in ISSUE and HOLD.
REQ-013 The block SHALL have port done  output  1  high in DONE.
REQ-014 The block SHALL have port issued  output  4  count of instructions issued since the last start, wrapping mod 16.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, HOLD, DONE.
REQ-016 Each entry SHALL be stored as {load_cycles, load_data} at the write pointer; the write pointer increments on accept.
REQ-017 load_ready SHALL be high only in IDLE or DONE with fewer than DEPTH entries stored; with the buffer full, load_valid is ignored.
REQ-018 IDLE or DONE + start + at least one entry stored -> ISSUE on the next edge, read pointer = 0, issued = 0; start with an empty buffer is ignored.
REQ-019 Transition to ISSUE SHALL drive data = entry instruction and w = 1, and increment issued, all from the same edge.
REQ-020 An entry with cycles k SHALL hold data and w = 1 for exactly k+1 clocks (k execute + 1 wait) before the next entry appears.
REQ-021 The next entry SHALL follow the previous one with no gap cycle.
REQ-022 After the last stored entry completes, or on reaching an entry with cycles = 0 (not issued), the FSM SHALL enter DONE: w = 0, data holds the last issued word, done = 1.
REQ-023 start in ISSUE or HOLD SHALL be ignored.
REQ-024 start in DONE SHALL restart from entry 0 with the program retained.
REQ-025 clear SHALL take effect from any state on the next edge: write pointer = 0, FSM = IDLE, w = 0, busy = 0, done = 0; data and issued retain their values.
REQ-026 Priority SHALL be reset > clear > start > load.
REQ-027 A load accepted in the same cycle as start SHALL be stored and included in the program.

Reset
REQ-028 reset SHALL force state IDLE, data = 0, w = 0, busy = 0, done = 0, issued = 0, load_ready = 1, and both pointers = 0, including mid-issue.
REQ-029 Buffer contents SHALL NOT need to be reset; they are unreachable while the write pointer is 0.

Configuration
REQ-030 With PROG_LOOP_EN defined, completing the last stored entry SHALL wrap to entry 0 with no gap, w staying high, until clear, reset, or an entry with cycles = 0.
REQ-031 Without PROG_LOOP_EN, the end of the program SHALL enter DONE per REQ-022.

Verification
REQ-032 Reset mid-HOLD -> next cycle data=0x000, w=0, busy=0, issued=0, load_ready=1.
REQ-033 Load 0x01D/k=1, 0x027/k=2, 0x2A0/k=1, then start -> w=1; data 0x01D for 2 clocks, 0x027 for 3 clocks, 0x2A0 for 2 clocks; then done=1, w=0, data=0x2A0, issued=3.
REQ-034 Load 8 entries, then a 9th -> load_ready=0 after the 8th; the 9th is not stored and the run issues exactly 8 words.
REQ-035 Load 0x1F9/k=3, 0x18D/k=0, 0x084/k=1, start -> only 0x1F9 is issued (4 clocks), then DONE with issued=1.
REQ-036 clear during HOLD -> IDLE next cycle, w=0; a following start is ignored until a new entry is loaded.
REQ-037 With PROG_LOOP_EN, two entries k=1 -> data alternates every 2 clocks indefinitely, done stays 0, and issued wraps 15->0.
